port_rd_dma: RTL and testbench

// - Egress stage downstream of the per-port write DMA and crossbar: pops 30-bit dispatch descriptors from the crossbar output FIFO.
// - For each descriptor, requests the packet from the MMU and streams the returned units into the egress output FIFO with sop/eop framing.
// - Only issues an MMU read when the output FIFO can absorb the whole packet, because MMU read data cannot be back-pressured.

---
 rtl/port_rd_dma_pkg.sv | 19 +
 rtl/rd_dma_framer.sv | 44 ++++
 rtl/port_rd_dma.sv | 136 +++++++++++++
 tb/tb_port_rd_dma.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_rd_dma_pkg.sv
// Shared definitions for the egress read DMA: dispatch descriptor layout and FSM states.
package port_rd_dma_pkg;

  localparam int DISPATCH_WIDTH = 30;
  localparam int ADDR_LSB       = 14;
  localparam int LEN_LSB        = 7;
  localparam int TAG_LSB        = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SPACE,
    ST_REQ,
    ST_RECV,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rd_dma_framer.sv
// Beat framer: counts accepted MMU beats, generates sop/eop and flags length mismatches.
module rd_dma_framer #(
  parameter int LEN_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_beat_en,
  input  logic             i_vld,
  input  logic             i_done,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_wr_en,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_err,
  output logic             o_fin
);

  logic [LEN_W-1:0] beat_cnt_q;
  logic             drain_q;
  logic             last;

  assign last    = (beat_cnt_q == (i_len - LEN_W'(1)));
  assign o_wr_en = i_beat_en & i_vld & ~drain_q;
  assign o_sop   = o_wr_en & (beat_cnt_q == '0);
  assign o_eop   = o_wr_en & (last | i_done);
  assign o_err   = o_wr_en & (last ^ i_done);
  // The packet is over only once the MMU signals done, even if eop was already framed.
  assign o_fin   = i_beat_en & i_vld & i_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_cnt_q <= '0;
      drain_q    <= 1'b0;
    end else if (i_start) begin
      beat_cnt_q <= '0;
      drain_q    <= 1'b0;
    end else if (o_wr_en) begin
      beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      if (o_eop && !i_done) drain_q <= 1'b1;
    end
  end

endmodule

// File: rtl/port_rd_dma.sv
// Egress read DMA: pops dispatch descriptors, reserves output-FIFO space, then streams MMU data out framed.
module port_rd_dma
  import port_rd_dma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 7,
  parameter int TAG_W  = 7,
  parameter int FREE_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DISPATCH_WIDTH-1:0] i_desc_dat,
  input  logic                      i_desc_empty,
  output logic                      o_desc_rd_en,
  output logic                      o_mmu_rd_req,
  output logic [ADDR_W-1:0]         o_mmu_rd_addr,
  output logic [LEN_W-1:0]          o_mmu_rd_len,
  input  logic                      i_mmu_rd_ready,
  input  logic                      i_mmu_rd_vld,
  input  logic [DATA_W-1:0]         i_mmu_rd_dat,
  input  logic                      i_mmu_rd_done,
  output logic                      o_of_wr_en,
  output logic [DATA_W-1:0]         o_of_din,
  output logic                      o_of_sop,
  output logic                      o_of_eop,
  input  logic [FREE_W-1:0]         i_of_free,
  output logic                      o_busy,
  output logic                      o_err,
  output logic [15:0]               o_pkt_cnt
);

  localparam int CMP_W = (LEN_W > FREE_W) ? LEN_W : FREE_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [TAG_W-1:0]  tag_q;
  logic [15:0]       pkt_cnt_q;

  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0]  desc_len;
  logic [TAG_W-1:0]  desc_tag;
  logic              desc_rd;
  logic              zero_len;
  logic              fits;
  logic              beat_en;
  logic              frm_err;
  logic              frm_fin;
  logic              unused_tag;

  assign desc_addr  = i_desc_dat[ADDR_LSB +: ADDR_W];
  assign desc_len   = i_desc_dat[LEN_LSB +: LEN_W];
  assign desc_tag   = i_desc_dat[TAG_LSB +: TAG_W];
  assign fits       = (CMP_W'(len_q) <= CMP_W'(i_of_free));
  assign unused_tag = ^tag_q;

  // MMU data cannot be stalled, so beats are accepted from the ready cycle onward.
  assign beat_en = ((state_q == ST_REQ) && i_mmu_rd_ready) || (state_q == ST_RECV);

  always_comb begin
    state_d  = state_q;
    desc_rd  = 1'b0;
    zero_len = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!i_desc_empty) begin
          desc_rd = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        if (desc_len == '0) begin
          zero_len = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_SPACE;
        end
      end
      ST_SPACE: if (fits) state_d = ST_REQ;
      ST_REQ: begin
        if (i_mmu_rd_ready) state_d = frm_fin ? ST_DONE : ST_RECV;
      end
      ST_RECV: if (frm_fin) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      tag_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LATCH) begin
        addr_q <= desc_addr;
        len_q  <= desc_len;
        tag_q  <= desc_tag;
      end
      if (state_q == ST_DONE) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  rd_dma_framer #(
    .LEN_W (LEN_W)
  ) u_framer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (state_q == ST_LATCH),
    .i_beat_en (beat_en),
    .i_vld     (i_mmu_rd_vld),
    .i_done    (i_mmu_rd_done),
    .i_len     (len_q),
    .o_wr_en   (o_of_wr_en),
    .o_sop     (o_of_sop),
    .o_eop     (o_of_eop),
    .o_err     (frm_err),
    .o_fin     (frm_fin)
  );

  // The FSM idles during reset, so the pop strobe is masked to keep outputs quiet.
  assign o_desc_rd_en  = desc_rd & ~i_rst;
  assign o_mmu_rd_req  = (state_q == ST_REQ);
  assign o_mmu_rd_addr = addr_q;
  assign o_mmu_rd_len  = len_q;
  assign o_of_din      = o_of_wr_en ? i_mmu_rd_dat : '0;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_err         = zero_len | frm_err;
  assign o_pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_port_rd_dma.sv
// Directed bench for port_rd_dma with a write scoreboard fed by the MMU beat driver.
module tb_port_rd_dma;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 7;
  localparam int FREE_W = 8;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [29:0]       i_desc_dat;
  logic              i_desc_empty;
  logic              o_desc_rd_en;
  logic              o_mmu_rd_req;
  logic [ADDR_W-1:0] o_mmu_rd_addr;
  logic [LEN_W-1:0]  o_mmu_rd_len;
  logic              i_mmu_rd_ready;
  logic              i_mmu_rd_vld;
  logic [DATA_W-1:0] i_mmu_rd_dat;
  logic              i_mmu_rd_done;
  logic              o_of_wr_en;
  logic [DATA_W-1:0] o_of_din;
  logic              o_of_sop;
  logic              o_of_eop;
  logic [FREE_W-1:0] i_of_free;
  logic              o_busy;
  logic              o_err;
  logic [15:0]       o_pkt_cnt;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int wr_cnt = 0;
  int req_cycles = 0;
  logic [33:0] exp_q[$];

  port_rd_dma dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_desc_dat     (i_desc_dat),
    .i_desc_empty   (i_desc_empty),
    .o_desc_rd_en   (o_desc_rd_en),
    .o_mmu_rd_req   (o_mmu_rd_req),
    .o_mmu_rd_addr  (o_mmu_rd_addr),
    .o_mmu_rd_len   (o_mmu_rd_len),
    .i_mmu_rd_ready (i_mmu_rd_ready),
    .i_mmu_rd_vld   (i_mmu_rd_vld),
    .i_mmu_rd_dat   (i_mmu_rd_dat),
    .i_mmu_rd_done  (i_mmu_rd_done),
    .o_of_wr_en     (o_of_wr_en),
    .o_of_din       (o_of_din),
    .o_of_sop       (o_of_sop),
    .o_of_eop       (o_of_eop),
    .i_of_free      (i_of_free),
    .o_busy         (o_busy),
    .o_err          (o_err),
    .o_pkt_cnt      (o_pkt_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] mk_desc(input logic [15:0] a, input logic [6:0] l, input logic [6:0] t);
    return {a, l, t};
  endfunction

  // Output-FIFO side: every write is matched against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_err) err_cnt++;
      if (o_mmu_rd_req) req_cycles++;
      if (o_of_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("write_expected", 64'(exp_q.size()), 64'd1);
        else chk("of_write{din,sop,eop}", 64'({o_of_din, o_of_sop, o_of_eop}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic load_desc(input logic [29:0] d);
    logic got;
    got = 1'b0;
    i_desc_dat   = d;
    i_desc_empty = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (o_desc_rd_en) begin
        got = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    i_desc_empty = 1'b1;
    chk("desc_pop", 64'(got), 64'd1);
  endtask

  task automatic do_req(input logic [15:0] a, input logic [6:0] l, input int delay,
                        input logic beat_in_ready, input logic [31:0] bdat);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      if (o_mmu_rd_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("req_seen", 64'(seen), 64'd1);
    for (int k = 0; k < delay; k++) begin
      chk("req_held", 64'(o_mmu_rd_req), 64'd1);
      chk("req_addr", 64'(o_mmu_rd_addr), 64'(a));
      chk("req_len", 64'(o_mmu_rd_len), 64'(l));
      @(posedge i_clk); #1;
    end
    i_mmu_rd_ready = 1'b1;
    if (beat_in_ready) begin
      i_mmu_rd_vld  = 1'b1;
      i_mmu_rd_dat  = bdat;
      i_mmu_rd_done = 1'b1;
      exp_q.push_back({bdat, 1'b1, 1'b1});
    end
    chk("req_addr_at_ready", 64'(o_mmu_rd_addr), 64'(a));
    @(posedge i_clk); #1;
    i_mmu_rd_ready = 1'b0;
    i_mmu_rd_vld   = 1'b0;
    i_mmu_rd_done  = 1'b0;
    chk("req_dropped", 64'(o_mmu_rd_req), 64'd0);
  endtask

  task automatic send_beats(input logic [31:0] base, input int n, input int done_idx, input int len);
    int last_w;
    last_w = (done_idx < len - 1) ? done_idx : len - 1;
    for (int i = 0; i < n; i++) begin
      i_mmu_rd_vld  = 1'b1;
      i_mmu_rd_dat  = base + 32'(i);
      i_mmu_rd_done = (i == done_idx);
      if (i <= last_w) exp_q.push_back({base + 32'(i), (i == 0), (i == last_w)});
      @(posedge i_clk); #1;
    end
    i_mmu_rd_vld  = 1'b0;
    i_mmu_rd_done = 1'b0;
  endtask

  task automatic finish_pkt(input int exp_pkt, input int exp_err);
    for (int k = 0; k < 30; k++) begin
      if (!o_busy) break;
      @(posedge i_clk); #1;
    end
    chk("busy_idle", 64'(o_busy), 64'd0);
    chk("pkt_cnt", 64'(o_pkt_cnt), 64'(exp_pkt));
    chk("err_total", 64'(err_cnt), 64'(exp_err));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int wr_before;
    int req_before;
    i_rst = 1'b1;
    i_desc_dat = '0;
    i_desc_empty = 1'b1;
    i_mmu_rd_ready = 1'b0;
    i_mmu_rd_vld = 1'b0;
    i_mmu_rd_dat = '0;
    i_mmu_rd_done = 1'b0;
    i_of_free = 8'd64;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_req", 64'(o_mmu_rd_req), 64'd0);
    chk("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    chk("rst_addr", 64'(o_mmu_rd_addr), 64'd0);
    i_rst = 1'b0;

    // Single packet, ready two cycles after req.
    load_desc(mk_desc(16'h0140, 7'd4, 7'h12));
    do_req(16'h0140, 7'd4, 2, 1'b0, 32'h0);
    send_beats(32'hA000_0000, 4, 3, 4);
    finish_pkt(1, 0);
    chk("single_writes", 64'(wr_cnt), 64'd4);

    // Output FIFO back-pressure, with the exact-fit boundary.
    i_of_free = 8'd5;
    load_desc(mk_desc(16'h2222, 7'd10, 7'h05));
    repeat (6) begin @(posedge i_clk); #1; end
    chk("bp_no_req_free5", 64'(o_mmu_rd_req), 64'd0);
    chk("bp_busy", 64'(o_busy), 64'd1);
    i_of_free = 8'd9;
    repeat (3) begin @(posedge i_clk); #1; end
    chk("bp_no_req_free9", 64'(o_mmu_rd_req), 64'd0);
    i_of_free = 8'd10;
    @(posedge i_clk); #1;
    chk("bp_req_free10", 64'(o_mmu_rd_req), 64'd1);
    do_req(16'h2222, 7'd10, 3, 1'b0, 32'h0);
    send_beats(32'hB000_0000, 10, 9, 10);
    finish_pkt(2, 0);
    i_of_free = 8'd64;

    // len 1 with the single beat landing in the ready cycle.
    load_desc(mk_desc(16'h0333, 7'd1, 7'h01));
    do_req(16'h0333, 7'd1, 1, 1'b1, 32'hC0DE_0001);
    finish_pkt(3, 0);

    // len 0: error pulse and no request, then the next descriptor runs.
    req_before = req_cycles;
    load_desc(mk_desc(16'h0444, 7'd0, 7'h02));
    repeat (3) begin @(posedge i_clk); #1; end
    chk("len0_err", 64'(err_cnt), 64'd1);
    chk("len0_no_req", 64'(req_cycles), 64'(req_before));
    chk("len0_idle", 64'(o_busy), 64'd0);
    load_desc(mk_desc(16'h0555, 7'd2, 7'h03));
    do_req(16'h0555, 7'd2, 0, 1'b0, 32'h0);
    send_beats(32'hD000_0000, 2, 1, 2);
    finish_pkt(4, 1);

    // Early done: len 8, done on beat 5.
    wr_before = wr_cnt;
    load_desc(mk_desc(16'h0666, 7'd8, 7'h04));
    do_req(16'h0666, 7'd8, 1, 1'b0, 32'h0);
    send_beats(32'hE000_0000, 6, 5, 8);
    finish_pkt(5, 2);
    chk("early_writes", 64'(wr_cnt - wr_before), 64'd6);

    // Late done: len 3, done on beat 4; beats 3-4 dropped.
    wr_before = wr_cnt;
    load_desc(mk_desc(16'h0777, 7'd3, 7'h06));
    do_req(16'h0777, 7'd3, 0, 1'b0, 32'h0);
    send_beats(32'hF000_0000, 5, 4, 3);
    finish_pkt(6, 3);
    chk("late_writes", 64'(wr_cnt - wr_before), 64'd3);

    // Reset in the middle of a 6-beat packet.
    load_desc(mk_desc(16'h0888, 7'd6, 7'h07));
    do_req(16'h0888, 7'd6, 0, 1'b0, 32'h0);
    send_beats(32'h1000_0000, 3, 99, 6);
    i_rst = 1'b1;
    i_mmu_rd_vld = 1'b1;
    i_mmu_rd_dat = 32'h1000_0003;
    #1;
    chk("midrst_wr_en", 64'(o_of_wr_en), 64'd0);
    chk("midrst_eop", 64'(o_of_eop), 64'd0);
    chk("midrst_din", 64'(o_of_din), 64'd0);
    chk("midrst_req", 64'(o_mmu_rd_req), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_err", 64'(o_err), 64'd0);
    chk("midrst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    chk("midrst_len", 64'(o_mmu_rd_len), 64'd0);
    i_mmu_rd_vld = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    load_desc(mk_desc(16'h0999, 7'd2, 7'h08));
    do_req(16'h0999, 7'd2, 1, 1'b0, 32'h0);
    send_beats(32'h2000_0000, 2, 1, 2);
    finish_pkt(1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
